// File: rtl/reg_native_pkg.sv
// Shared types and helpers for native register-file blocks: FSM state encoding
// and word/index sizing helpers.
package reg_native_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / BITS_PER_BYTE;
    endfunction

    function automatic int unsigned idx_width(input int unsigned reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

endpackage

// File: rtl/regfile_rsp_if.sv
// Request/acknowledge bus between a requester (master) and the register file (slave).
interface regfile_rsp_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  req_vld;
    logic                  req_rdy;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ack_vld;
    logic                  ack_rdy;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output req_vld, rd_en, wr_en, addr, wr_data, ack_rdy,
        input  req_rdy, ack_vld, rd_data
    );

    modport slave (
        input  req_vld, rd_en, wr_en, addr, wr_data, ack_rdy,
        output req_rdy, ack_vld, rd_data
    );

endinterface

// File: rtl/regfile_rsp_dec.sv
// Combinational byte-address to register-index decode with in-range flag
// (below base, misaligned or past the last register are all out of range).
module regfile_rsp_dec
    import reg_native_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 64,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            REG_NUM    = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    output logic [idx_width(REG_NUM)-1:0] idx,
    output logic                         in_range
);

    localparam int unsigned BPW     = bytes_per_word(DATA_WIDTH);
    localparam int unsigned ALIGN_W = $clog2(BPW);
    localparam int unsigned IDX_W   = idx_width(REG_NUM);

    logic [ADDR_WIDTH-1:0] offs;
    logic [ADDR_WIDTH-1:0] word;

    assign offs     = addr - BASE_ADDR;
    assign word     = offs >> ALIGN_W;
    assign in_range = (addr >= BASE_ADDR)
                   && ((offs & ADDR_WIDTH'(BPW - 1)) == '0)
                   && (word < ADDR_WIDTH'(REG_NUM));
    assign idx      = IDX_W'(word);

endmodule

// File: rtl/regfile_rsp.sv
// Register file with valid/ready request and acknowledge handshake.
// Optional err output when built with REGFILE_RSP_ERR_EN.
module regfile_rsp
    import reg_native_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           REG_NUM    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          glb_srst,
    regfile_rsp_if.slave                  bus,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
`ifdef REGFILE_RSP_ERR_EN
    ,
    output logic                          err
`endif
);

    localparam int unsigned IDX_W = idx_width(REG_NUM);

    state_t                state;
    logic                  req_rdy_q;
    logic                  ack_vld_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  cap_rd;
    logic                  cap_wr;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [IDX_W-1:0]      idx;
    logic                  in_range;

    regfile_rsp_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_NUM    (REG_NUM),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .addr     (cap_addr),
        .idx      (idx),
        .in_range (in_range)
    );

`ifdef REGFILE_RSP_ERR_EN
    logic err_q;
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (glb_srst) begin
            err_q <= 1'b0;
        end else if (state == EXEC) begin
            err_q <= ~in_range;
        end else if (state == ACK && bus.ack_rdy) begin
            err_q <= 1'b0;
        end
    end
`endif

    // Request FSM; the access itself happens in EXEC on the captured request.
    always_ff @(posedge clk) begin
        if (glb_srst) begin
            state     <= IDLE;
            req_rdy_q <= 1'b1;
            ack_vld_q <= 1'b0;
            rd_data_q <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_vld) begin
                        cap_rd    <= bus.rd_en;
                        cap_wr    <= bus.wr_en;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wr_data;
                        req_rdy_q <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cap_wr && in_range) begin
                        regs[idx] <= cap_wdata;
                    end
                    rd_data_q <= (cap_rd && !cap_wr && in_range) ? regs[idx] : '0;
                    ack_vld_q <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    if (bus.ack_rdy) begin
                        ack_vld_q <= 1'b0;
                        rd_data_q <= '0;
                        req_rdy_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ack_vld_q <= 1'b0;
                    rd_data_q <= '0;
                    req_rdy_q <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_rdy = req_rdy_q;
    assign bus.ack_vld = ack_vld_q;
    assign bus.rd_data = rd_data_q;

    for (genvar g = 0; g < int'(REG_NUM); g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: doc/regfile_rsp.md
REGFILE_RSP -- requirements
Module: regfile_rsp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter REG_NUM, default 8, number of registers; minimum 1.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of register 0.
REQ-005 SHALL have parameter RST_VAL, default 0, reset value of every register.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port glb_srst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-008 SHALL have port req_vld, input, 1 bit: request valid.
REQ-009 SHALL have port req_rdy, output, 1 bit: request ready.
REQ-010 SHALL have ports rd_en and wr_en, input, 1 bit each: read and write request.
REQ-011 SHALL have port addr, input, ADDR_WIDTH bits: byte address.
REQ-012 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port ack_vld, output, 1 bit: response valid.
REQ-014 SHALL have port ack_rdy, input, 1 bit: response accepted.
REQ-015 SHALL have port rd_data, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port reg_q, output, REG_NUM*DATA_WIDTH bits: register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-017 SHALL implement states IDLE, EXEC, ACK.
REQ-018 SHALL drive req_rdy=1 only in IDLE.
REQ-019 SHALL, on req_vld&&req_rdy, capture rd_en, wr_en, addr and wr_data, then go IDLE->EXEC.
REQ-020 SHALL go EXEC->ACK unconditionally after 1 cycle and perform the access in EXEC: update the register for a write, register rd_data for a read.
REQ-021 SHALL drive ack_vld=1 only in ACK, holding rd_data stable until ack_rdy=1, then go ACK->IDLE.
REQ-022 SHALL have latency of accept in cycle N -> ack_vld in cycle N+2; with ack_rdy held high, the next accept is possible in cycle N+3.
REQ-023 SHALL decode the index as (addr-BASE_ADDR)/(DATA_WIDTH/8), using full ADDR_WIDTH arithmetic.
REQ-024 SHALL treat addr<BASE_ADDR, index>=REG_NUM, or a misaligned address (low log2(DATA_WIDTH/8) bits nonzero) as out of range.
REQ-025 SHALL make an out-of-range write change no register, and make an out-of-range read return rd_data=0; both still acknowledge.
REQ-026 SHALL give write priority when rd_en and wr_en are both 1: perform the write and return rd_data=0.
REQ-027 SHALL acknowledge a request with rd_en=wr_en=0 without side effects and with rd_data=0.
REQ-028 SHALL drive rd_data=0 outside ACK.
REQ-029 SHALL update reg_q in the cycle after EXEC of a write.

Reset
REQ-030 SHALL, with glb_srst=1 at a clk edge, go to IDLE from any state, abandon any in-flight request, and not perform it.
REQ-031 SHALL hold after reset: req_rdy=1, ack_vld=0, rd_data=0, every register=RST_VAL.
REQ-032 SHALL give glb_srst priority over a simultaneous req_vld or ack_rdy.

Configuration
REQ-033 SHALL, with macro REGFILE_RSP_ERR_EN defined, add output port err, 1 bit, equal to 1 in ACK when the request was out of range, otherwise 0, and reset to 0.
REQ-034 SHALL, without REGFILE_RSP_ERR_EN, have no err port; all other behaviour is identical.

Structure
REQ-035 SHALL place the state typedef enum (IDLE, EXEC, ACK) and the helper constant for bytes-per-word in shared package reg_native_pkg.
REQ-036 SHALL implement address decode (index, in-range flag) as sub-module regfile_rsp_dec, purely combinational.

Verification
REQ-037 SHALL test a write: addr=0x8, wr_data=0xDEADBEEF, default params -> ack_vld at N+2, reg_q[2]=0xDEADBEEF.
REQ-038 SHALL test a read-back: read addr=0x8 after REQ-037 -> rd_data=0xDEADBEEF while ack_vld=1.
REQ-039 SHALL test backpressure: ack_rdy=0 for 5 cycles -> ack_vld and rd_data held stable, req_rdy=0 throughout.
REQ-040 SHALL test out-of-range: write addr=0x20 and read addr=0x6 -> no reg_q change, rd_data=0, err=1 with REGFILE_RSP_ERR_EN.
REQ-041 SHALL test reset mid-operation: glb_srst=1 in EXEC of write addr=0x0 -> reg_q[0]=RST_VAL, ack_vld never asserted, req_rdy=1 next cycle.
REQ-042 SHALL test simultaneous rd_en=wr_en=1: addr=0x4, wr_data=0x5 -> reg_q[1]=0x5, rd_data=0.
